// File: rtl/fifo_ring_param.sv
// fifo_ring_param
//   Parametrised first-word-fall-through ring-buffer FIFO for the
//   noise-canceling datapath. It buffers audio samples between the
//   acquisition bus and the adaptive filter.
//
//   Features: arbitrary DEPTH (power of 2 not required) and DWIDTH, a fill
//   count, programmable almost_full / almost_empty levels, and sticky
//   overflow / underflow flags.
//
//   Optional feature, macro FIFO_PEEK_EN:
//     When defined, the peek_idx / peek_data / peek_valid ports exist.
//     They give random read access at an offset from the head, which the
//     filter uses to read its taps. When the macro is undefined, those
//     ports and their logic are absent.
//
// Handshake (single rule for both sides):
//   wr_ce and rd_ce are single-cycle requests sampled at the rising edge.
//   - A write is accepted when the FIFO is not full, or when a read is
//     requested in the same cycle; the slot being popped is reused.
//   - A read is accepted only when the FIFO holds data.
//   - A rejected request changes no storage, pointer or count. Its only
//     effect is to set the matching sticky error flag.
//   - data_out always shows the head word. A read consumes it at the edge.
`timescale 1ns/1ps

module fifo_ring_param #(
  parameter int DWIDTH   = 32,
  parameter int DEPTH    = 64,
  parameter int AF_LEVEL = 60,
  parameter int AE_LEVEL = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_ce,
  input  logic              rd_ce,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              err_clr,
  output logic [DWIDTH-1:0] data_out,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
`ifdef FIFO_PEEK_EN
  ,
  input  logic [AW-1:0]     peek_idx,
  output logic [DWIDTH-1:0] peek_data,
  output logic              peek_valid
`endif
);

  // Storage array. It is not reset: the count decides which words are live.
  logic [DWIDTH-1:0] mem_q [DEPTH];

  // Architectural state with its next-state values.
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          ovf_q,    ovf_d;
  logic          udf_q,    udf_d;

  // Decoded status from the count register.
  logic is_full;
  logic is_empty;

  // Accepted operations and error events for this cycle.
  logic wr_acc;
  logic rd_acc;
  logic ovf_set;
  logic udf_set;

  // Status decode: every flag is a function of the registered count only,
  // so the flags move one cycle after the operation that changed the count.
  always_comb begin
    is_full  = (count_q == CW'(DEPTH));
    is_empty = (count_q == '0);
  end

  // Request qualification. A write into a full FIFO is accepted only when a
  // pop happens in the same cycle and frees the slot.
  always_comb begin
    wr_acc  = wr_ce & (~is_full | rd_ce);
    rd_acc  = rd_ce & ~is_empty;
    ovf_set = wr_ce & is_full & ~rd_ce;
    udf_set = rd_ce & is_empty;
  end

  // Next-state logic for the pointers, the count and the sticky flags.
  // Pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths work.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Setting a flag beats clearing it in the same cycle, so an error that
    // lands on the clear pulse is not lost.
    ovf_d = ovf_set | (ovf_q & ~err_clr);
    udf_d = udf_set | (udf_q & ~err_clr);
  end

  // State register. The synchronous reset takes priority over every request.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage write. It is gated by reset so that a request in a reset cycle
  // leaves no trace.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // Output decode. The head word falls through combinationally and is
  // forced to zero while empty.
  always_comb begin
    data_out     = is_empty ? '0 : mem_q[rd_ptr_q];
    count        = count_q;
    full         = is_full;
    empty        = is_empty;
    almost_full  = (count_q >= CW'(AF_LEVEL));
    almost_empty = (count_q <= CW'(AE_LEVEL));
    overflow     = ovf_q;
    underflow    = udf_q;
  end

`ifdef FIFO_PEEK_EN
  // Peek address is (rd_ptr + peek_idx) mod DEPTH.
  // For any valid index the sum is below 2*DEPTH, so one conditional
  // subtract is enough. Invalid indices are masked off by peek_valid.
  logic [AW:0] peek_sum;
  logic [AW:0] peek_wrap;
  logic [AW-1:0] peek_addr;

  // Tap-peek read path, fully combinational from registers and peek_idx.
  always_comb begin
    peek_sum   = {1'b0, rd_ptr_q} + {1'b0, peek_idx};
    peek_wrap  = (peek_sum >= (AW+1)'(DEPTH)) ? peek_sum - (AW+1)'(DEPTH) : peek_sum;
    peek_addr  = peek_wrap[AW-1:0];
    peek_valid = (CW'(peek_idx) < count_q);
    peek_data  = peek_valid ? mem_q[peek_addr] : '0;
  end
`endif

endmodule

// File: tb/tb_fifo_ring_param.sv
// tb_fifo_ring_param
//   Drives one 64-deep and one 5-deep FIFO with the same request stream.
//   Each instance is checked every cycle against its own queue-based model
//   of the FIFO rules.
//   Build with +define+FIFO_PEEK_EN to also cover the tap-peek port.
`timescale 1ns/1ps

module tb_fifo_ring_param;

  // Clock and reset signals.
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     = 1'b1;
  logic        wr_ce   = 1'b0;
  logic        rd_ce   = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] data_in = '0;

  // Instance A: DEPTH 64, AF 60, AE 4.
  logic [31:0] dout_a;
  logic [6:0]  cnt_a;
  logic        full_a, empty_a, af_a, ae_a, ov_a, un_a;

  // Instance B: DEPTH 5, AF 4, AE 1.
  logic [31:0] dout_b;
  logic [2:0]  cnt_b;
  logic        full_b, empty_b, af_b, ae_b, ov_b, un_b;

`ifdef FIFO_PEEK_EN
  logic [5:0]  pidx_a = '0;
  logic [31:0] pdat_a;
  logic        pval_a;
  logic [2:0]  pidx_b = '0;
  logic [31:0] pdat_b;
  logic        pval_b;
`endif

  fifo_ring_param #(.DWIDTH(32), .DEPTH(64), .AF_LEVEL(60), .AE_LEVEL(4)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .wr_ce        (wr_ce),
    .rd_ce        (rd_ce),
    .data_in      (data_in),
    .err_clr      (err_clr),
    .data_out     (dout_a),
    .count        (cnt_a),
    .full         (full_a),
    .empty        (empty_a),
    .almost_full  (af_a),
    .almost_empty (ae_a),
    .overflow     (ov_a),
    .underflow    (un_a)
`ifdef FIFO_PEEK_EN
    ,
    .peek_idx     (pidx_a),
    .peek_data    (pdat_a),
    .peek_valid   (pval_a)
`endif
  );

  fifo_ring_param #(.DWIDTH(32), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .wr_ce        (wr_ce),
    .rd_ce        (rd_ce),
    .data_in      (data_in),
    .err_clr      (err_clr),
    .data_out     (dout_b),
    .count        (cnt_b),
    .full         (full_b),
    .empty        (empty_b),
    .almost_full  (af_b),
    .almost_empty (ae_b),
    .overflow     (ov_b),
    .underflow    (un_b)
`ifdef FIFO_PEEK_EN
    ,
    .peek_idx     (pidx_b),
    .peek_data    (pdat_b),
    .peek_valid   (pval_b)
`endif
  );

  // Reference model: one queue per instance holds the live words in order,
  // head at index 0.
  int          dep [2] = '{64, 5};
  int          afl [2] = '{60, 4};
  int          ael [2] = '{4, 1};
  logic [31:0] mq  [2][$];
  bit          m_ov [2];
  bit          m_un [2];

  int n_total = 0;
  int n_bad   = 0;

  // Scoreboard check: counts the comparison and reports a mismatch.
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance both models by one clock edge, using the requests as driven.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int n;
      bit f, e, ovs, uns;
      if (rst) begin
        mq[k].delete();
        m_ov[k] = 1'b0;
        m_un[k] = 1'b0;
      end else begin
        n   = mq[k].size();
        f   = (n == dep[k]);
        e   = (n == 0);
        ovs = wr_ce && f && !rd_ce;
        uns = rd_ce && e;
        if (rd_ce && !e) void'(mq[k].pop_front());
        if (wr_ce && (!f || rd_ce)) mq[k].push_back(data_in);
        m_ov[k] = ovs | (m_ov[k] & !err_clr);
        m_un[k] = uns | (m_un[k] & !err_clr);
      end
    end
  endtask

  // Compare one instance's outputs with its model.
  task automatic check_inst(input int k, input string p, input logic [31:0] dout,
                            input logic [31:0] cnt, input logic fl, input logic em,
                            input logic af, input logic ae, input logic ov, input logic un);
    int n;
    n = mq[k].size();
    check_val({p, ".count"}, cnt, n);
    check_val({p, ".full"}, {31'd0, fl}, {31'd0, n == dep[k]});
    check_val({p, ".empty"}, {31'd0, em}, {31'd0, n == 0});
    check_val({p, ".afull"}, {31'd0, af}, {31'd0, n >= afl[k]});
    check_val({p, ".aempty"}, {31'd0, ae}, {31'd0, n <= ael[k]});
    check_val({p, ".ovf"}, {31'd0, ov}, {31'd0, m_ov[k]});
    check_val({p, ".udf"}, {31'd0, un}, {31'd0, m_un[k]});
    check_val({p, ".dout"}, dout, (n > 0) ? mq[k][0] : 32'd0);
  endtask

`ifdef FIFO_PEEK_EN
  // Compare a peek port with the model: the entry idx places behind the head.
  task automatic check_peek(input int k, input string p, input int idx,
                            input logic [31:0] pd, input logic pv);
    bit v;
    v = (idx < mq[k].size());
    check_val({p, ".pvalid"}, {31'd0, pv}, {31'd0, v});
    check_val({p, ".pdata"}, pd, v ? mq[k][idx] : 32'd0);
  endtask
`endif

  // Check both instances against their models.
  task automatic check_all();
    check_inst(0, "a", dout_a, {25'd0, cnt_a}, full_a, empty_a, af_a, ae_a, ov_a, un_a);
    check_inst(1, "b", dout_b, {29'd0, cnt_b}, full_b, empty_b, af_b, ae_b, ov_b, un_b);
`ifdef FIFO_PEEK_EN
    check_peek(0, "a", int'(pidx_a), pdat_a, pval_a);
    check_peek(1, "b", int'(pidx_b), pdat_b, pval_b);
`endif
  endtask

  // Driver: apply one cycle of requests, step the model at the edge, then
  // check outputs on the falling edge.
  task automatic cycle(input logic r, input logic w, input logic rd,
                       input logic [31:0] d, input logic ec);
    rst = r; wr_ce = w; rd_ce = rd; data_in = d; err_clr = ec;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    // 1: reset values.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 1, 32'h1234, 0);
    check_val("s1.empty", {31'd0, empty_a}, 32'd1);
    check_val("s1.count", {25'd0, cnt_a}, 32'd0);
    check_val("s1.dout", dout_a, 32'd0);
    check_val("s1.aempty", {31'd0, ae_a}, 32'd1);

    // 2: fill 1..64, then drain in order.
    for (int i = 1; i <= 64; i++) cycle(0, 1, 0, i, 0);
    check_val("s2.full", {31'd0, full_a}, 32'd1);
    check_val("s2.afull", {31'd0, af_a}, 32'd1);
    for (int i = 1; i <= 64; i++) begin
      check_val("s2.order", dout_a, i);
      cycle(0, 0, 1, 0, 0);
    end
    check_val("s2.empty", {31'd0, empty_a}, 32'd1);
    // Reset asserted in the middle of a write burst.
    for (int i = 0; i < 30; i++) cycle(0, 1, 0, 32'h500 + i, 0);
    cycle(1, 1, 0, 32'hdead, 0);
    check_val("s2.rst_count", {25'd0, cnt_a}, 32'd0);
    check_val("s2.rst_dout", dout_a, 32'd0);

    // 3: overflow on a full FIFO, then clear it.
    for (int i = 0; i < 64; i++) cycle(0, 1, 0, 32'h100 + i, 0);
    cycle(0, 1, 0, 32'haa, 0);
    check_val("s3.ovf", {31'd0, ov_a}, 32'd1);
    check_val("s3.count", {25'd0, cnt_a}, 32'd64);
    cycle(0, 0, 0, 0, 1);
    check_val("s3.ovf_clr", {31'd0, ov_a}, 32'd0);
    for (int i = 0; i < 64; i++) begin
      check_val("s3.order", dout_a, 32'h100 + i);
      cycle(0, 0, 1, 0, 0);
    end

    // 4: simultaneous write and read on an empty FIFO.
    cycle(0, 1, 1, 32'h55, 0);
    check_val("s4.count", {25'd0, cnt_a}, 32'd1);
    check_val("s4.udf", {31'd0, un_a}, 32'd1);
    check_val("s4.dout", dout_a, 32'h55);
    cycle(0, 0, 0, 0, 1);

    // 5: DEPTH 5 held at count 3 through 20 push-and-pop cycles.
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 32'h200 + i, 0);
    for (int i = 3; i < 23; i++) begin
      cycle(0, 1, 1, 32'h200 + i, 0);
      check_val("s5.count_b", {29'd0, cnt_b}, 32'd3);
      check_val("s5.dout_b", dout_b, 32'h200 + i - 2);
    end
    cycle(1, 1, 1, 32'h999, 0);
    check_val("s5.rst_count_b", {29'd0, cnt_b}, 32'd0);
    check_val("s5.rst_empty_b", {31'd0, empty_b}, 32'd1);

`ifdef FIFO_PEEK_EN
    // 6: tap peek.
    for (int i = 10; i <= 19; i++) cycle(0, 1, 0, i, 0);
    pidx_a = 6'd3; #1;
    check_val("s6.pdata3", pdat_a, 32'd13);
    check_val("s6.pvalid3", {31'd0, pval_a}, 32'd1);
    pidx_a = 6'd12; #1;
    check_val("s6.pvalid12", {31'd0, pval_a}, 32'd0);
    check_val("s6.pdata12", pdat_a, 32'd0);
    pidx_a = 6'd3;
    cycle(0, 0, 1, 0, 0);
    check_val("s6.pdata3_pop", pdat_a, 32'd14);
`endif

    // 7: random traffic with phases biased towards filling and draining.
    for (int i = 0; i < 3000; i++) begin
      int wp;
      wp = ((i / 250) % 2 == 1) ? 75 : 30;
`ifdef FIFO_PEEK_EN
      pidx_a = 6'($urandom_range(0, 63));
      pidx_b = 3'($urandom_range(0, 7));
`endif
      cycle(($urandom_range(0, 599) == 0),
            ($urandom_range(0, 99) < wp),
            ($urandom_range(0, 99) < (100 - wp)),
            $urandom,
            ($urandom_range(0, 29) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
